sgdmac_cmd_splitter: RTL and testbench

SGDMAC_CMD_SPLITTER -- requirements
Module: sgdmac_cmd_splitter

---
 rtl/sgdmac_cmd_splitter_pkg.sv | 9 +
 rtl/sgdmac_cmd_splitter_if.sv | 35 +++
 rtl/sgdmac_cmd_splitter_chunk_calc.sv | 18 +
 rtl/sgdmac_cmd_splitter.sv | 92 +++++++++
 tb/tb_sgdmac_cmd_splitter.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/sgdmac_cmd_splitter_pkg.sv
// sgdmac_cmd_splitter_pkg: shared FSM state enum, command width and command struct for the splitter
package sgdmac_pkg;
    localparam int CMD_DATA_LEN = 48;
    typedef enum logic [2:0] {IDLE, CALC, EMIT_RD, EMIT_WR, FIN} state_t;
    typedef struct packed {
        logic [31:0] addr;
        logic [15:0] byte_cnt;
    } cmd_t;
endpackage

// File: rtl/sgdmac_cmd_splitter_if.sv
// sgdmac_cmd_splitter_if: descriptor and command handshake bundle; err_o exists only with SGDMAC_ALIGN_CHECK_EN
interface sgdmac_cmd_splitter_if;
    import sgdmac_pkg::*;
    logic                    desc_valid_i;
    logic                    desc_ready_o;
    logic [31:0]             desc_src_i;
    logic [31:0]             desc_dst_i;
    logic [15:0]             desc_len_i;
    logic                    cmd_valid_o;
    logic                    cmd_ready_i;
    logic                    cmd_rw_o;
    logic [CMD_DATA_LEN-1:0] cmd_data_o;
    logic                    busy_o;
    logic                    done_o;
`ifdef SGDMAC_ALIGN_CHECK_EN
    logic                    err_o;
    modport slave (
        input  desc_valid_i, desc_src_i, desc_dst_i, desc_len_i, cmd_ready_i,
        output desc_ready_o, cmd_valid_o, cmd_rw_o, cmd_data_o, busy_o, done_o, err_o
    );
    modport master (
        output desc_valid_i, desc_src_i, desc_dst_i, desc_len_i, cmd_ready_i,
        input  desc_ready_o, cmd_valid_o, cmd_rw_o, cmd_data_o, busy_o, done_o, err_o
    );
`else
    modport slave (
        input  desc_valid_i, desc_src_i, desc_dst_i, desc_len_i, cmd_ready_i,
        output desc_ready_o, cmd_valid_o, cmd_rw_o, cmd_data_o, busy_o, done_o
    );
    modport master (
        output desc_valid_i, desc_src_i, desc_dst_i, desc_len_i, cmd_ready_i,
        input  desc_ready_o, cmd_valid_o, cmd_rw_o, cmd_data_o, busy_o, done_o
    );
`endif
endinterface

// File: rtl/sgdmac_cmd_splitter_chunk_calc.sv
// sgdmac_chunk_calc: combinational min of remaining, max burst and room to the next src/dst boundary
module sgdmac_chunk_calc #(
    parameter int MAX_BURST_BYTES = 64,
    parameter int BOUNDARY_BYTES  = 4096
) (
    input  logic [15:0] remaining,
    input  logic [31:0] src,
    input  logic [31:0] dst,
    output logic [15:0] chunk
);
    logic [16:0] src_room, dst_room, m_burst, m_src, m_dst;
    assign src_room = 17'(BOUNDARY_BYTES) - 17'(src % 32'(BOUNDARY_BYTES));
    assign dst_room = 17'(BOUNDARY_BYTES) - 17'(dst % 32'(BOUNDARY_BYTES));
    assign m_burst  = ({1'b0, remaining} < 17'(MAX_BURST_BYTES)) ? {1'b0, remaining} : 17'(MAX_BURST_BYTES);
    assign m_src    = (m_burst < src_room) ? m_burst : src_room;
    assign m_dst    = (m_src < dst_room) ? m_src : dst_room;
    assign chunk    = 16'(m_dst);
endmodule

// File: rtl/sgdmac_cmd_splitter.sv
// sgdmac_cmd_splitter: splits a copy descriptor into paired read/write commands that never cross a boundary; SGDMAC_ALIGN_CHECK_EN adds a sticky alignment error
module sgdmac_cmd_splitter
    import sgdmac_pkg::*;
#(
    parameter int MAX_BURST_BYTES = 64,
    parameter int BOUNDARY_BYTES  = 4096
) (
    input logic               clk,
    input logic               rst,
    sgdmac_cmd_splitter_if.slave bus
);
    state_t      state, state_n;
    logic [31:0] src, dst;
    logic [15:0] remaining, chunk, chunk_n;
    logic        accept, cmd_ok, misaligned;
    cmd_t        cmd;

    assign accept = bus.desc_valid_i && state == IDLE;
    assign cmd_ok = bus.cmd_valid_o && bus.cmd_ready_i;

`ifdef SGDMAC_ALIGN_CHECK_EN
    logic err;
    assign misaligned = |{bus.desc_src_i[1:0], bus.desc_dst_i[1:0], bus.desc_len_i[1:0]};
    assign bus.err_o  = err;
    // sticky error set by a misaligned accepted descriptor, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst)
            err <= 1'b0;
        else if (accept && misaligned)
            err <= 1'b1;
    end
`else
    assign misaligned = 1'b0;
`endif

    sgdmac_chunk_calc #(
        .MAX_BURST_BYTES(MAX_BURST_BYTES),
        .BOUNDARY_BYTES (BOUNDARY_BYTES)
    ) u_chunk_calc (
        .remaining(remaining),
        .src      (src),
        .dst      (dst),
        .chunk    (chunk_n)
    );

    // next-state logic; the write handshake retires the chunk so the last pair leads to FIN
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = accept ? ((bus.desc_len_i == 16'd0 || misaligned) ? FIN : CALC) : IDLE;
            CALC:    state_n = EMIT_RD;
            EMIT_RD: state_n = bus.cmd_ready_i ? EMIT_WR : EMIT_RD;
            EMIT_WR: state_n = bus.cmd_ready_i ? ((remaining == chunk) ? FIN : CALC) : EMIT_WR;
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // state and datapath registers; addresses wrap naturally at 2^32
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            src       <= '0;
            dst       <= '0;
            remaining <= '0;
            chunk     <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                src       <= bus.desc_src_i;
                dst       <= bus.desc_dst_i;
                remaining <= bus.desc_len_i;
            end
            if (state == CALC)
                chunk <= chunk_n;
            if (state == EMIT_WR && cmd_ok) begin
                src       <= src + 32'(chunk);
                dst       <= dst + 32'(chunk);
                remaining <= remaining - chunk;
            end
        end
    end

    assign cmd.addr         = (state == EMIT_WR) ? dst : src;
    assign cmd.byte_cnt     = chunk;
    assign bus.desc_ready_o = state == IDLE;
    assign bus.cmd_valid_o  = state == EMIT_RD || state == EMIT_WR;
    assign bus.cmd_rw_o     = state == EMIT_WR;
    assign bus.cmd_data_o   = bus.cmd_valid_o ? cmd : '0;
    assign bus.busy_o       = state != IDLE;
    assign bus.done_o       = state == FIN;
endmodule

// File: tb/tb_sgdmac_cmd_splitter.sv
// tb_sgdmac_cmd_splitter: directed checks of command splitting, stalls, reset abort and zero-length descriptors
module tb_sgdmac_cmd_splitter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   failed = 0;
    int   done_cnt = 0;
    logic [48:0] q[$];

    sgdmac_cmd_splitter_if bus();

    sgdmac_cmd_splitter dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // record every accepted command as {rw, addr, byte_cnt} and every done pulse
    always @(posedge clk) begin
        if (!rst) begin
            if (bus.cmd_valid_o && bus.cmd_ready_i)
                q.push_back({bus.cmd_rw_o, bus.cmd_data_o});
            if (bus.done_o)
                done_cnt++;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_cmd(input string tag, input int i, input logic rw, input logic [31:0] a, input logic [15:0] c);
        logic [48:0] g;
        g = (i < q.size()) ? q[i] : '1;
        check(tag, 64'(g), 64'({rw, a, c}));
    endtask

    task automatic send_desc(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l);
        @(negedge clk);
        for (int n = 0; n < 100 && !bus.desc_ready_o; n++)
            @(negedge clk);
        check("desc_ready_wait", 64'(bus.desc_ready_o), 64'd1);
        bus.desc_src_i   = s;
        bus.desc_dst_i   = d;
        bus.desc_len_i   = l;
        bus.desc_valid_i = 1'b1;
        @(posedge clk);
        #1 bus.desc_valid_i = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        for (int n = 0; n < 300 && done_cnt == d0; n++)
            @(posedge clk);
        repeat (3) @(posedge clk);
        check("done_once", 64'(done_cnt), 64'(d0 + 1));
    endtask

    initial begin
        int b, d0;
        bus.desc_valid_i = 1'b0;
        bus.desc_src_i   = '0;
        bus.desc_dst_i   = '0;
        bus.desc_len_i   = '0;
        bus.cmd_ready_i  = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_desc_ready", 64'(bus.desc_ready_o), 64'd1);
        check("rst_busy", 64'(bus.busy_o), 64'd0);
        check("rst_cmd_valid", 64'(bus.cmd_valid_o), 64'd0);
        check("rst_done", 64'(bus.done_o), 64'd0);
        check("rst_cmd_data", 64'(bus.cmd_data_o), 64'd0);
        check("rst_cmd_rw", 64'(bus.cmd_rw_o), 64'd0);
`ifdef SGDMAC_ALIGN_CHECK_EN
        check("rst_err", 64'(bus.err_o), 64'd0);
`endif

        // single aligned burst
        bus.cmd_ready_i = 1'b1;
        b = q.size(); d0 = done_cnt;
        send_desc(32'h1000, 32'h2000, 16'd64);
        wait_done(d0);
        check("basic_count", 64'(q.size()), 64'(b + 2));
        check_cmd("basic_rd", b, 1'b0, 32'h1000, 16'd64);
        check_cmd("basic_wr", b + 1, 1'b1, 32'h2000, 16'd64);

        // boundary-limited then burst-limited then remainder
        b = q.size(); d0 = done_cnt;
        send_desc(32'h0FF0, 32'h3000, 16'd100);
        wait_done(d0);
        check("split_count", 64'(q.size()), 64'(b + 6));
        check_cmd("split_rd0", b,     1'b0, 32'h0FF0, 16'd16);
        check_cmd("split_wr0", b + 1, 1'b1, 32'h3000, 16'd16);
        check_cmd("split_rd1", b + 2, 1'b0, 32'h1000, 16'd64);
        check_cmd("split_wr1", b + 3, 1'b1, 32'h3010, 16'd64);
        check_cmd("split_rd2", b + 4, 1'b0, 32'h1040, 16'd20);
        check_cmd("split_wr2", b + 5, 1'b1, 32'h3050, 16'd20);

        // address wrap at 2^32 with the boundary limiting the first chunk to 4 bytes
        b = q.size(); d0 = done_cnt;
        send_desc(32'hFFFF_FFFC, 32'h0000_0100, 16'd8);
        wait_done(d0);
        check("wrap_count", 64'(q.size()), 64'(b + 4));
        check_cmd("wrap_rd0", b,     1'b0, 32'hFFFF_FFFC, 16'd4);
        check_cmd("wrap_wr0", b + 1, 1'b1, 32'h0000_0100, 16'd4);
        check_cmd("wrap_rd1", b + 2, 1'b0, 32'h0000_0000, 16'd4);
        check_cmd("wrap_wr1", b + 3, 1'b1, 32'h0000_0104, 16'd4);

        // zero length: straight to FIN, no commands
        b = q.size();
        send_desc(32'h1000, 32'h2000, 16'd0);
        @(negedge clk);
        check("len0_done", 64'(bus.done_o), 64'd1);
        check("len0_valid", 64'(bus.cmd_valid_o), 64'd0);
        @(negedge clk);
        check("len0_done_drop", 64'(bus.done_o), 64'd0);
        check("len0_ready", 64'(bus.desc_ready_o), 64'd1);
        check("len0_no_cmd", 64'(q.size()), 64'(b));

        // backpressure during EMIT_RD keeps the command stable
        bus.cmd_ready_i = 1'b0;
        b = q.size(); d0 = done_cnt;
        send_desc(32'h4000, 32'h5000, 16'd8);
        for (int n = 0; n < 20 && !bus.cmd_valid_o; n++)
            @(negedge clk);
        for (int n = 0; n < 5; n++) begin
            check("stall_valid", 64'(bus.cmd_valid_o), 64'd1);
            check("stall_data", 64'(bus.cmd_data_o), 64'({32'h4000, 16'd8}));
            check("stall_rw", 64'(bus.cmd_rw_o), 64'd0);
            @(negedge clk);
        end
        bus.cmd_ready_i = 1'b1;
        wait_done(d0);
        check_cmd("stall_rd", b,     1'b0, 32'h4000, 16'd8);
        check_cmd("stall_wr", b + 1, 1'b1, 32'h5000, 16'd8);

        // reset in EMIT_WR abandons the descriptor
        bus.cmd_ready_i = 1'b0;
        b = q.size();
        send_desc(32'h8000, 32'h9000, 16'd256);
        for (int n = 0; n < 20 && !bus.cmd_valid_o; n++)
            @(negedge clk);
        bus.cmd_ready_i = 1'b1;
        @(posedge clk);
        #1 bus.cmd_ready_i = 1'b0;
        @(negedge clk);
        check("abort_in_wr", 64'({bus.cmd_valid_o, bus.cmd_rw_o}), 64'b11);
        rst = 1'b1;
        @(negedge clk);
        check("abort_valid", 64'(bus.cmd_valid_o), 64'd0);
        check("abort_busy", 64'(bus.busy_o), 64'd0);
        check("abort_ready", 64'(bus.desc_ready_o), 64'd1);
        rst = 1'b0;
        bus.cmd_ready_i = 1'b1;
        repeat (6) @(posedge clk);
        check("abort_count", 64'(q.size()), 64'(b + 1));
        check_cmd("abort_rd", b, 1'b0, 32'h8000, 16'd64);

`ifdef SGDMAC_ALIGN_CHECK_EN
        b = q.size(); d0 = done_cnt;
        send_desc(32'h1002, 32'h2000, 16'd16);
        @(negedge clk);
        check("align_err", 64'(bus.err_o), 64'd1);
        check("align_done", 64'(bus.done_o), 64'd1);
        wait_done(d0);
        check("align_no_cmd", 64'(q.size()), 64'(b));
        check("align_sticky", 64'(bus.err_o), 64'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
